wspr_tx_scheduler: RTL

Sequences one WSPR transmission. It waits for a start request and a valid encoded message, then reads the 162 two-bit channel symbols from the encoder's symbol buffer in order. Each symbol is presented as a tone index for exactly SYMBOL_CYCLES clocks to the quadrature/delta-sigma modulator, which also receives the LO gating. It sits between the encoder's symbol store and the modulator inside the UART top level.

---
 rtl/wspr_pkg.sv | 13 +
 rtl/wspr_tx_scheduler_if.sv | 26 ++
 rtl/sync_rise_detect.sv | 26 ++
 rtl/wspr_tx_scheduler.sv | 124 ++++++++++++
 4 files changed

// File: rtl/wspr_pkg.sv
// Shared constants and state encoding for the WSPR transmit scheduler.
// One WSPR message is 162 two-bit channel symbols.
package wspr_pkg;
  localparam int NUM_SYMBOLS = 162;
  localparam int SYM_IDX_W   = 8;
  localparam int TONE_W      = 2;
  localparam logic [SYM_IDX_W-1:0] LAST_SYMBOL =
    SYM_IDX_W'(NUM_SYMBOLS - 1);

  typedef enum logic [2:0] {
    IDLE, ARMED, GUARD, LOAD, SEND, DONE
  } state_t;
endpackage

// File: rtl/wspr_tx_scheduler_if.sv
// Scheduler control, symbol-buffer read port and modulator drive.
// slave = scheduler side, master = surrounding system.
interface wspr_tx_scheduler_if;
  import wspr_pkg::*;

  logic                 start_transmission;
  logic                 abort;
  logic                 encoding_valid;
  logic [SYM_IDX_W-1:0] sym_addr;
  logic [TONE_W-1:0]    sym_data;
  logic [TONE_W-1:0]    tone;
  logic                 lo_enable;
  logic                 tx_active;
  logic [SYM_IDX_W-1:0] sym_index;
  logic                 tx_done;

  modport master (
    output start_transmission, abort, encoding_valid, sym_data,
    input  sym_addr, tone, lo_enable, tx_active, sym_index, tx_done
  );

  modport slave (
    input  start_transmission, abort, encoding_valid, sym_data,
    output sym_addr, tone, lo_enable, tx_active, sym_index, tx_done
  );
endinterface

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous pin plus a registered
// one-clock rising-edge pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);
  logic meta;
  logic stable;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= din;
      stable <= meta;
      prev   <= stable;
      pulse  <= stable & ~prev;
    end
  end
endmodule

// File: rtl/wspr_tx_scheduler.sv
// Steps through the 162 WSPR symbols, holding each tone for
// SYMBOL_CYCLES clocks after a short LO-on guard lead-in.
module wspr_tx_scheduler
  import wspr_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 6826667,
  parameter int CNT_W         = 23,
  parameter int GUARD_CYCLES  = 16
) (
  input logic               clk,
  input logic               reset,
  wspr_tx_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] SYM_LAST =
    CNT_W'(SYMBOL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST =
    CNT_W'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);
  localparam state_t FIRST = (GUARD_CYCLES > 0) ? GUARD : LOAD;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [TONE_W-1:0]    tone_q;
  logic [SYM_IDX_W-1:0] idx_q;
  logic [SYM_IDX_W-1:0] addr_q;
  logic                 start_pulse;
  logic                 kill;
  logic                 sym_term;
  logic                 on_air;
  logic                 done;

  sync_rise_detect u_start (
    .clk   (clk),
    .reset (reset),
    .din   (bus.start_transmission),
    .pulse (start_pulse)
  );

  // A dropped encoding_valid means the buffer may be rewritten
  assign kill     = bus.abort | ~bus.encoding_valid;
  assign sym_term = (cnt == SYM_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (start_pulse)
          state_next = bus.encoding_valid ? FIRST : ARMED;
      ARMED:
        if (bus.abort)               state_next = IDLE;
        else if (bus.encoding_valid) state_next = FIRST;
      GUARD:
        if (kill)                    state_next = IDLE;
        else if (cnt == GUARD_LAST)  state_next = LOAD;
      LOAD:
        state_next = kill ? IDLE : SEND;
      SEND:
        if (kill) state_next = IDLE;
        else if (sym_term && idx_q == LAST_SYMBOL)
          state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    on_air = 1'b0;
    done   = 1'b0;
    unique case (1'b1)
      (state inside {GUARD, LOAD, SEND}): on_air = 1'b1;
      (state == DONE):                    done   = 1'b1;
      default: ;
    endcase
  end

  // sym_addr runs one symbol ahead so sym_data is ready at the boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      tone_q <= '0;
      idx_q  <= '0;
      addr_q <= '0;
    end else if (state_next == IDLE || state_next == DONE) begin
      cnt    <= '0;
      tone_q <= '0;
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        GUARD:
          cnt <= (state_next == LOAD) ? '0 : cnt + CNT_W'(1);
        LOAD: begin
          tone_q <= bus.sym_data;
          idx_q  <= '0;
          addr_q <= SYM_IDX_W'(1);
          cnt    <= '0;
        end
        SEND:
          if (sym_term) begin
            tone_q <= bus.sym_data;
            idx_q  <= idx_q + SYM_IDX_W'(1);
            addr_q <= (addr_q == LAST_SYMBOL) ? addr_q
                                              : addr_q + SYM_IDX_W'(1);
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        default: ;
      endcase
    end
  end

  assign bus.tone      = tone_q;
  assign bus.sym_addr  = addr_q;
  assign bus.sym_index = idx_q;
  assign bus.lo_enable = on_air;
  assign bus.tx_active = on_air;
  assign bus.tx_done   = done;
endmodule
